// File: rtl/intersection_sequencer.sv
// intersection_sequencer: two-road light sequencer with min/max green, pedestrian walk and emergency all-red
module intersection_sequencer #(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 2,
  parameter int ALLRED    = 1,
  parameter int WALK      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    A_GRN = 3'd0, A_YEL = 3'd1, AR_AB = 3'd2, B_GRN = 3'd3,
    B_YEL = 3'd4, AR_BA = 3'd5, PED   = 3'd6, EMERG = 3'd7
  } state_t;
  localparam logic [CNT_W-1:0] T_MIN  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED - 1);
  localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] t;
  logic             nxt_side, side_n;
  always_comb begin
    state_n = state;
    side_n  = nxt_side;
    case (state)
      A_GRN: state_n = (emergency || (t >= T_MIN && (!ta || (t >= T_MAX && (tb || ped_pend))))) ? A_YEL : A_GRN;
      A_YEL: state_n = (t == T_YEL) ? AR_AB : A_YEL;
      AR_AB: begin
        state_n = (t != T_AR) ? AR_AB : emergency ? EMERG : ped_pend ? PED : B_GRN;
        side_n  = (t == T_AR && !emergency && ped_pend) ? 1'b1 : nxt_side;
      end
      B_GRN: state_n = (emergency || (t >= T_MIN && (!tb || (t >= T_MAX && (ta || ped_pend))))) ? B_YEL : B_GRN;
      B_YEL: state_n = (t == T_YEL) ? AR_BA : B_YEL;
      AR_BA: begin
        state_n = (t != T_AR) ? AR_BA : emergency ? EMERG : ped_pend ? PED : A_GRN;
        side_n  = (t == T_AR && !emergency && ped_pend) ? 1'b0 : nxt_side;
      end
      PED:   state_n = emergency ? EMERG : (t != T_WALK) ? PED : nxt_side ? B_GRN : A_GRN;
      EMERG: begin
        state_n = emergency ? EMERG : A_GRN;
        side_n  = emergency ? nxt_side : 1'b1;
      end
      default: state_n = A_GRN;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= A_GRN;
      t        <= '0;
      ped_pend <= 1'b0;
      nxt_side <= 1'b1;
    end else begin
      state    <= state_n;
      nxt_side <= side_n;
      t        <= (state_n != state) ? '0 : (&t) ? t : t + 1'b1;
      ped_pend <= (state_n == PED && state != PED) ? 1'b0 : (ped_pend | ped_req);
    end
  end
  assign la    = (state == A_GRN) ? 2'b00 : (state == A_YEL) ? 2'b01 : 2'b10;
  assign lb    = (state == B_GRN) ? 2'b00 : (state == B_YEL) ? 2'b01 : 2'b10;
  assign walk  = (state == PED);
  assign phase = state;
endmodule

// File: tb/tb_intersection_sequencer.sv
// tb_intersection_sequencer: table vectors, corner sequences and random stimulus against a cycle model
module tb_intersection_sequencer;
  logic clk = 1'b0, reset = 1'b1, ta = 1'b0, tb = 1'b0, ped_req = 1'b0, emergency = 1'b0;
  logic [1:0] la, lb;
  logic walk, ped_pend;
  logic [2:0] phase;
  int errors = 0, checks = 0;
  int mph, mt, mped, mside;
  int la_tab[8] = '{0, 1, 2, 2, 2, 2, 2, 2};
  int lb_tab[8] = '{2, 2, 2, 0, 1, 2, 2, 2};
  typedef struct {
    logic a, b, p, e;
    logic [1:0] xla, xlb;
    logic [2:0] xph;
  } vec_t;
  vec_t v[7];

  intersection_sequencer dut (
    .clk(clk), .reset(reset), .ta(ta), .tb(tb), .ped_req(ped_req), .emergency(emergency),
    .la(la), .lb(lb), .walk(walk), .ped_pend(ped_pend), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model_la", la, la_tab[mph]);
    chk("model_lb", lb, lb_tab[mph]);
    chk("model_walk", walk, int'(mph == 6));
    chk("model_ped_pend", ped_pend, mped);
    chk("model_phase", phase, mph);
  endtask

  task automatic model_reset();
    mph = 0; mt = 0; mped = 0; mside = 1;
  endtask

  // durations from the parameter list: min green 4, max green 12, yellow 2, all-red 1, walk 3
  task automatic model_step(input bit a, input bit b, input bit p, input bit e);
    int np;
    np = mph;
    if (mph == 0 && (e || (mt + 1 >= 4 && (!a || (mt + 1 >= 12 && (b || mped != 0)))))) np = 1;
    if (mph == 3 && (e || (mt + 1 >= 4 && (!b || (mt + 1 >= 12 && (a || mped != 0)))))) np = 4;
    if ((mph == 1 || mph == 4) && mt + 1 == 2) np = mph + 1;
    if ((mph == 2 || mph == 5) && mt + 1 == 1) begin
      np = e ? 7 : (mped != 0) ? 6 : (mph == 2) ? 3 : 0;
      if (np == 6) mside = (mph == 2) ? 1 : 0;
    end
    if (mph == 6) np = e ? 7 : (mt + 1 == 3) ? (mside != 0 ? 3 : 0) : 6;
    if (mph == 7 && !e) begin
      np = 0;
      mside = 1;
    end
    if (np == 6 && mph != 6) mped = 0;
    else if (p) mped = 1;
    mt = (np != mph) ? 0 : (mt < 255 ? mt + 1 : 255);
    mph = np;
  endtask

  task automatic cyc(input bit a, input bit b, input bit p, input bit e);
    ta = a; tb = b; ped_req = p; emergency = e;
    @(posedge clk);
    model_step(a, b, p, e);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; ta = 0; tb = 0; ped_req = 0; emergency = 0;
    model_reset();
    #1 cmp_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n, wcnt, ecnt;
    bit e;
    v[0] = '{0, 1, 0, 0, 2'b00, 2'b10, 3'd0};
    v[1] = '{0, 1, 0, 0, 2'b00, 2'b10, 3'd0};
    v[2] = '{0, 1, 0, 0, 2'b00, 2'b10, 3'd0};
    v[3] = '{0, 1, 0, 0, 2'b01, 2'b10, 3'd1};
    v[4] = '{0, 1, 0, 0, 2'b01, 2'b10, 3'd1};
    v[5] = '{0, 1, 0, 0, 2'b10, 2'b10, 3'd2};
    v[6] = '{0, 1, 0, 0, 2'b10, 2'b00, 3'd3};
    model_reset();
    #2 do_reset();
    chk("reset_la", la, 0);
    chk("reset_lb", lb, 2);
    chk("reset_phase", phase, 0);
    chk("reset_ped_pend", ped_pend, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(v[i].a, v[i].b, v[i].p, v[i].e);
      chk($sformatf("vec%0d_la", i), la, v[i].xla);
      chk($sformatf("vec%0d_lb", i), lb, v[i].xlb);
      chk($sformatf("vec%0d_phase", i), phase, v[i].xph);
    end
    // both roads busy: max green ends A after 12 cycles
    do_reset();
    repeat (11) cyc(1, 1, 0, 0);
    chk("maxgreen_hold", phase, 0);
    cyc(1, 1, 0, 0);
    chk("maxgreen_exit", phase, 1);
    do_reset();
    repeat (40) cyc(1, 0, 0, 0);
    chk("green_indefinite", phase, 0);
    // pedestrian walk between A and B
    do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("ped_latched", ped_pend, 1);
    wcnt = 0; n = 0;
    while (phase != 3 && n < 20) begin
      cyc(0, 0, 0, 0);
      if (walk) begin
        wcnt++;
        chk("walk_both_red", {la, lb}, 4'b1010);
        if (wcnt == 1) chk("ped_cleared_at_entry", ped_pend, 0);
      end
      n++;
    end
    chk("walk_cycles", wcnt, 3);
    chk("after_walk_b_green", phase, 3);
    // emergency from A green
    do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("emerg_yel0", phase, 1);
    cyc(0, 0, 0, 1);
    chk("emerg_yel1", phase, 1);
    cyc(0, 0, 0, 1);
    chk("emerg_allred", phase, 2);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1);
      chk("emerg_hold", phase, 7);
    end
    cyc(0, 0, 0, 0);
    chk("emerg_release", phase, 0);
    // async reset in the middle of B yellow
    do_reset();
    n = 0;
    while (phase != 4 && n < 30) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("reach_b_yel", phase, 4);
    cyc(0, 0, 1, 0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("midreset_la", la, 0);
    chk("midreset_lb", lb, 2);
    chk("midreset_walk", walk, 0);
    chk("midreset_phase", phase, 0);
    chk("midreset_ped", ped_pend, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cyc(0, 0, 0, 0);
    chk("restart_min_green", phase, 0);
    cyc(0, 0, 0, 0);
    chk("restart_yel", phase, 1);
    // ped_req on the PED entry edge is swallowed, later one queues a second walk
    do_reset();
    cyc(0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0);
    chk("pre_ped_allred", phase, 2);
    cyc(0, 0, 1, 0);
    chk("ped_entry_walk", walk, 1);
    chk("ped_entry_clear", ped_pend, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("ped_in_walk_latch", ped_pend, 1);
    cyc(0, 0, 0, 0);
    chk("walk_to_b", phase, 3);
    n = 0;
    while (!walk && n < 20) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("second_walk", walk, 1);
    repeat (3) cyc(0, 0, 0, 0);
    chk("second_walk_to_a", phase, 0);
    // random traffic against the model
    do_reset();
    ecnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ecnt > 0) ecnt--;
      else if ($urandom_range(63) == 0) ecnt = $urandom_range(15, 1);
      e = (ecnt > 0);
      if ($urandom_range(499) == 0) do_reset();
      else cyc(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(7) == 0), e);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
